dmem_ctrl: RTL and testbench

- Data-memory access controller for the accumulator MCU. It takes load/store requests from the control unit and runs a request/acknowledge transaction on the external data RAM.
- It returns load data to the register bank through the dmem_data/dmem_update pair, which the register bank consumes.
- Stores take their write data from the accumulator operand path.
- A watchdog flags a RAM that never acknowledges.

---
 rtl/dmem_ctrl_pkg.sv | 22 ++
 rtl/dmc_watchdog.sv | 32 +++
 rtl/dmem_ctrl.sv | 128 ++++++++++++
 tb/tb_dmem_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory access controller.
//   dmc_state_e : FSM state encodings (IDLE / ACCESS / ERR)
//   DMC_*       : default widths and watchdog timeout
//   dmc_cnt_w   : watchdog counter width for a given timeout
package dmem_ctrl_pkg;

  typedef enum logic [1:0] {
    DMC_IDLE   = 2'd0,
    DMC_ACCESS = 2'd1,
    DMC_ERR    = 2'd2
  } dmc_state_e;

  localparam int DMC_DATA_WIDTH = 8;
  localparam int DMC_ADDR_WIDTH = 8;
  localparam int DMC_TIMEOUT    = 15;

  // clog2(t+1) bits, never less than one
  function automatic int dmc_cnt_w(input int t);
    return (t < 1) ? 1 : $clog2(t + 1);
  endfunction

endpackage

// File: rtl/dmc_watchdog.sv
// Saturating cycle counter with synchronous clear and count enable.
//   clk, rst : clock, async active-low reset
//   clr      : load counter with zero (has priority over en)
//   en       : count one cycle
//   tc       : terminal count, high while count == TIMEOUT-1 (never when TIMEOUT=0)
module dmc_watchdog
  import dmem_ctrl_pkg::*;
#(
  parameter int TIMEOUT = DMC_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW   = dmc_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] SAT  = CW'(TIMEOUT);
  localparam logic [CW-1:0] TERM = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                   cnt <= '0;
    else if (clr)               cnt <= '0;
    else if (en && cnt != SAT)  cnt <= cnt + 1'b1;
  end

  assign tc = (TIMEOUT > 0) && (cnt == TERM);

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory access controller: runs one req/ack transaction on the data RAM
// per CPU load/store and returns load data to the register bank.
//   cpu_req/cpu_we/cpu_addr/cpu_wdata : request from control unit (taken in IDLE)
//   busy/done/err/err_clr             : status, completion pulse, sticky watchdog error
//   dmem_update/dmem_data             : load-data strobe and held load data
//   mem_req/mem_we/mem_addr/mem_wdata : RAM request side, stable until ack
//   mem_rdata/mem_ack                 : RAM response side
module dmem_ctrl
  import dmem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = DMC_DATA_WIDTH,
  parameter int ADDR_WIDTH = DMC_ADDR_WIDTH,
  parameter int TIMEOUT    = DMC_TIMEOUT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  input  logic                  err_clr,
  output logic                  dmem_update,
  output logic [DATA_WIDTH-1:0] dmem_data,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);

  dmc_state_e            state, state_nx;
  logic                  busy_nx, done_nx, err_nx, upd_nx, req_nx, we_nx;
  logic [DATA_WIDTH-1:0] data_nx, wdata_nx;
  logic [ADDR_WIDTH-1:0] addr_nx;
  logic                  wd_clr, wd_en, wd_tc;

  dmc_watchdog #(.TIMEOUT(TIMEOUT)) u_wd (
    .clk (clk),
    .rst (rst),
    .clr (wd_clr),
    .en  (wd_en),
    .tc  (wd_tc)
  );

  always_comb begin
    state_nx = state;
    req_nx   = mem_req;
    we_nx    = mem_we;
    addr_nx  = mem_addr;
    wdata_nx = mem_wdata;
    data_nx  = dmem_data;
    err_nx   = err;
    done_nx  = 1'b0;
    upd_nx   = 1'b0;
    wd_clr   = 1'b0;
    wd_en    = 1'b0;
    case (state)
      DMC_IDLE: begin
        if (cpu_req) begin
          req_nx   = 1'b1;
          we_nx    = cpu_we;
          addr_nx  = cpu_addr;
          wdata_nx = cpu_wdata;
          wd_clr   = 1'b1;
          state_nx = DMC_ACCESS;
        end
      end
      DMC_ACCESS: begin
        wd_en = !mem_ack;
        // ack beats the terminal count when both land in the same cycle
        if (mem_ack) begin
          req_nx  = 1'b0;
          we_nx   = 1'b0;
          done_nx = 1'b1;
          if (!mem_we) begin
            data_nx = mem_rdata;
            upd_nx  = 1'b1;
          end
          state_nx = DMC_IDLE;
        end else if (wd_tc) begin
          req_nx   = 1'b0;
          we_nx    = 1'b0;
          err_nx   = 1'b1;
          state_nx = DMC_ERR;
        end
      end
      DMC_ERR: begin
        if (err_clr) begin
          err_nx   = 1'b0;
          state_nx = DMC_IDLE;
        end
      end
      default: state_nx = DMC_IDLE;
    endcase
    busy_nx = (state_nx != DMC_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= DMC_IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      dmem_update <= 1'b0;
      dmem_data   <= '0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_nx;
      busy        <= busy_nx;
      done        <= done_nx;
      err         <= err_nx;
      dmem_update <= upd_nx;
      dmem_data   <= data_nx;
      mem_req     <= req_nx;
      mem_we      <= we_nx;
      mem_addr    <= addr_nx;
      mem_wdata   <= wdata_nx;
    end
  end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl (TIMEOUT=4). Expected load data is queued when
// a load is issued and popped when the load-data strobe is observed.
module tb_dmem_ctrl;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req, cpu_we, err_clr, mem_ack;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata, mem_rdata;
  logic          busy, done, err, dmem_update, mem_req, mem_we;
  logic [DW-1:0] dmem_data, mem_wdata;
  logic [AW-1:0] mem_addr;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];

  always #5 clk = ~clk;

  dmem_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .busy(busy), .done(done), .err(err), .err_clr(err_clr),
    .dmem_update(dmem_update), .dmem_data(dmem_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_pop(input string tag);
    logic [DW-1:0] e;
    chk({tag, "_sb_nonempty"}, 32'(exp_q.size() > 0), 32'd1);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk(tag, 32'(dmem_data), 32'(e));
    end
  endtask

  task automatic issue(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = wd;
  endtask

  initial begin
    rst = 1'b0; cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    err_clr = 0; mem_ack = 0; mem_rdata = '0;
    #12;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_upd", 32'(dmem_update), 0);
    chk("rst_req", 32'(mem_req), 0);
    chk("rst_we", 32'(mem_we), 0);
    chk("rst_data", 32'(dmem_data), 0);
    chk("rst_addr", 32'(mem_addr), 0);
    chk("rst_wdata", 32'(mem_wdata), 0);
    rst = 1'b1;
    step();

    // zero-wait load
    issue(1'b0, 8'h3C, 8'h00); exp_q.push_back(8'hA5);
    step(); cpu_req = 0;
    chk("zl_req", 32'(mem_req), 1);
    chk("zl_we", 32'(mem_we), 0);
    chk("zl_addr", 32'(mem_addr), 32'h3C);
    chk("zl_busy", 32'(busy), 1);
    chk("zl_done_early", 32'(done), 0);
    mem_ack = 1; mem_rdata = 8'hA5;
    step(); mem_ack = 0; mem_rdata = '0;
    chk("zl_done", 32'(done), 1);
    chk("zl_upd", 32'(dmem_update), 1);
    sb_pop("zl_data");
    chk("zl_req_off", 32'(mem_req), 0);
    chk("zl_busy_off", 32'(busy), 0);
    step();
    chk("zl_done_pulse", 32'(done), 0);
    chk("zl_upd_pulse", 32'(dmem_update), 0);

    // back-to-back loads, second request in the done cycle
    issue(1'b0, 8'h01, 8'h00); exp_q.push_back(8'h11);
    step(); cpu_req = 0;
    chk("bb1_req", 32'(mem_req), 1);
    mem_ack = 1; mem_rdata = 8'h11;
    step(); mem_ack = 0;
    chk("bb1_upd", 32'(dmem_update), 1);
    sb_pop("bb1_data");
    issue(1'b0, 8'h02, 8'h00); exp_q.push_back(8'h22);
    step(); cpu_req = 0;
    chk("bb2_req", 32'(mem_req), 1);
    chk("bb2_addr", 32'(mem_addr), 32'h02);
    chk("bb2_upd_gap", 32'(dmem_update), 0);
    mem_ack = 1; mem_rdata = 8'h22;
    step(); mem_ack = 0;
    chk("bb2_upd", 32'(dmem_update), 1);
    sb_pop("bb2_data");
    step();
    chk("bb_req_off", 32'(mem_req), 0);

    // store with 3 wait cycles; ack lands on the terminal-count cycle
    issue(1'b1, 8'h10, 8'h5A);
    step(); cpu_req = 0; cpu_we = 0;
    for (int i = 0; i < 4; i++) begin
      chk("st_req", 32'(mem_req), 1);
      chk("st_we", 32'(mem_we), 1);
      chk("st_wdata", 32'(mem_wdata), 32'h5A);
      chk("st_addr", 32'(mem_addr), 32'h10);
      chk("st_done_early", 32'(done), 0);
      if (i == 3) mem_ack = 1;
      step();
    end
    mem_ack = 0;
    chk("st_done", 32'(done), 1);
    chk("st_upd", 32'(dmem_update), 0);
    chk("st_data_hold", 32'(dmem_data), 32'h22);
    chk("st_err_tie", 32'(err), 0);
    chk("st_we_off", 32'(mem_we), 0);

    // watchdog timeout
    issue(1'b0, 8'h77, 8'h00);
    step(); cpu_req = 0;
    for (int i = 0; i < 4; i++) begin
      chk("to_req", 32'(mem_req), 1);
      chk("to_done", 32'(done), 0);
      chk("to_err_early", 32'(err), 0);
      step();
    end
    chk("to_req_off", 32'(mem_req), 0);
    chk("to_err", 32'(err), 1);
    chk("to_busy", 32'(busy), 1);
    chk("to_no_done", 32'(done), 0);
    issue(1'b0, 8'h78, 8'h00); mem_ack = 1;
    step(); cpu_req = 0; mem_ack = 0;
    chk("err_ign_req", 32'(mem_req), 0);
    chk("err_ign_busy", 32'(busy), 1);
    chk("err_sticky", 32'(err), 1);
    chk("err_ign_done", 32'(done), 0);
    chk("err_ign_upd", 32'(dmem_update), 0);
    err_clr = 1;
    step(); err_clr = 0;
    chk("clr_err", 32'(err), 0);
    chk("clr_busy", 32'(busy), 0);

    // async reset mid-ACCESS
    issue(1'b0, 8'h44, 8'h00);
    step(); cpu_req = 0;
    chk("mr_req", 32'(mem_req), 1);
    #2 rst = 1'b0;
    #1;
    chk("mr_req_off", 32'(mem_req), 0);
    chk("mr_busy", 32'(busy), 0);
    chk("mr_upd", 32'(dmem_update), 0);
    chk("mr_data", 32'(dmem_data), 0);
    #3 rst = 1'b1;
    step();
    chk("mr_idle_req", 32'(mem_req), 0);
    chk("mr_idle_done", 32'(done), 0);
    issue(1'b0, 8'h45, 8'h00); exp_q.push_back(8'hB7);
    step(); cpu_req = 0;
    chk("mr_new_req", 32'(mem_req), 1);
    chk("mr_new_addr", 32'(mem_addr), 32'h45);
    mem_ack = 1; mem_rdata = 8'hB7;
    step(); mem_ack = 0;
    chk("mr_new_upd", 32'(dmem_update), 1);
    sb_pop("mr_new_data");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
